regfile_bist_ctrl: RTL and testbench
====================================

Name: regfile_bist_ctrl

Overview:
- MBIST initiator that drives the 1RW test port of the register-file test wrapper (BIST, CSN_T, WEN_T, A_T, D_T, Q_T).
- Runs a March C- sequence over every writable register-file entry, compares read data, and reports pass/fail plus the first failing location.
- Sits beside the core; the SoC test controller or a debug CSR pulses start_i.

Parameters:
- ADDR_WIDTH, 5, width of the test address A_T.
- DATA_WIDTH, 32, width of the test data D_T/Q_T.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- setback_i  in  1  synchronous soft reset; returns the block to IDLE.
- start_i  in  1  one-cycle start pulse, honoured only in IDLE or DONE.
- busy_o  out  1  high while the test runs.
- done_o  out  1  sticky end-of-test flag; cleared by the next start.
- fail_o  out  1  sticky mismatch flag, valid when done_o=1.
- fail_addr_o  out  ADDR_WIDTH  A_T value of the first mismatch.
- fail_exp_o  out  DATA_WIDTH  expected data at the first mismatch.
- fail_act_o  out  DATA_WIDTH  Q_T value at the first mismatch.
- bist_o  out  1  wrapper BIST enable (muxes the RF port A).
- csn_t_o  out  1  test chip select, active-low.
- wen_t_o  out  1  test write enable, active-low; 1 means read.
- a_t_o  out  ADDR_WIDTH  test address.
- d_t_o  out  DATA_WIDTH  test write data.
- q_t_i  in  DATA_WIDTH  test read data.

Behaviour:
- Reset values (rst_n=0 or setback_i=1): all outputs 0, except csn_t_o=1 and wen_t_o=1.
- Address map (fixed by the wrapper):
  - a_t_o MSB is always 0.
  - The wrapper inverts the low bits, so internal address = ~A_T[ADDR_WIDTH-2:0].
  - Internal x0 is not writable, so the controller never issues A_T low bits = all ones.
  - Testable A_T range is 0..NADDR-1, where NADDR = 2^(ADDR_WIDTH-1)-1 (15 by default).
- Read timing:
  - A read cycle (csn=0, wen=1) is latched by the wrapper at the clock edge.
  - q_t_i is valid in the following cycle, which is the CHECK cycle. During CHECK, csn_t_o=1.
- Write timing: a write cycle (csn=0, wen=0) writes d_t_o at the clock edge.
- FSM states: IDLE, W0, RD, CHK, WR, DONE.
  - IDLE/DONE + start_i -> W0. busy_o=1 and bist_o=1 from the next cycle; done_o and fail_o are cleared.
  - March elements:
    - M0: ascending w0.
    - M1: ascending (r0, w1).
    - M2: ascending (r1, w0).
    - M3: descending (r0, w1).
    - M4: descending (r1, w0).
    - M5: descending r0.
  - "0" means all-zeros data; "1" means all-ones data.
  - Per address: M0 takes 1 cycle (W0). M1–M4 take 3 cycles (RD, CHK, WR). M5 takes 2 cycles (RD, CHK).
  - Ascending order is A_T 0..NADDR-1; descending is NADDR-1..0. The counter wraps to the start value when it moves to the next element.
- Run length: 15*NADDR cycles (225 by default) from the first bus cycle to DONE.
- Mismatch in CHK (q_t_i != expected):
  - Latch fail_addr/exp/act and set fail_o.
  - Abort directly to DONE; no further bus cycles are issued.
- DONE: busy_o=0, bist_o=0, done_o=1, csn_t_o=1. All outputs hold until the next start.
- start_i while busy is ignored.
- setback_i mid-test: the next cycle is IDLE with reset outputs, and the bus is released immediately.
- rst_n asserted mid-test: outputs go to reset values asynchronously.

Optional Feature:
- Macro: REGFILE_BIST_CHECKERBOARD_EN.
- Defined: after M5, the whole M0–M5 sequence repeats with background 0x5555_5555 in place of the "0" data and 0xAAAA_AAAA in place of the "1" data. Run length doubles (450 cycles by default). A failure in either pass aborts.
- Undefined: single all-zeros/all-ones pass only.

Decomposition:
- regfile_bist_pkg holds:
  - state enum bist_state_e.
  - march element enum march_elem_e (M0..M5).
  - per-element constants for direction, read flag, write flag, read-expected bit and write bit.
  - function naddr(ADDR_WIDTH).
- Sub-module regfile_bist_addr_gen: up/down address counter with load-to-start, last-address flag, and MSB forced to 0.

Test Plan:
- Fault-free RF, default parameters, start pulse:
  - done_o rises exactly 225 cycles after the first csn_t_o=0 cycle.
  - fail_o=0.
  - A_T never equals 5'h0F or any value with MSB=1.
- Stuck-at-1 on bit 3 of internal x5 (A_T=10):
  - Fail in M1 at RD/CHK of A_T 10.
  - fail_addr_o=10, fail_exp_o=0, fail_act_o=0x8.
  - No bus activity after the mismatch; bist_o=0.
- Stuck-at-0 on bit 31 of internal x15 (A_T=0):
  - First read-of-1 is in M2 ascending at A_T 0.
  - fail_addr_o=0, fail_exp_o=0xFFFF_FFFF, fail_act_o=0x7FFF_FFFF.
- setback_i asserted 40 cycles into the run:
  - Next cycle: busy_o=0, bist_o=0, csn_t_o=1.
  - A later start runs the full 225 cycles and passes.
- start_i pulsed at cycles 10 and 100 of a run: no restart, total still 225 cycles. After done_o, a new start clears done_o and fail_o.
- With REGFILE_BIST_CHECKERBOARD_EN defined and a fault-free RF:
  - 450 cycles, pass.
  - d_t_o takes values 0, FFFFFFFF, 55555555, AAAAAAAA only.

Source files
------------

// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg: shared FSM/march-element types and per-element constants for the RF MBIST controller
package regfile_bist_pkg;
  typedef enum logic [2:0] {IDLE, W0, RD, CHK, WR, DONE} bist_state_e;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
  localparam logic [5:0] EL_DOWN = 6'b111000;
  localparam logic [5:0] EL_RD   = 6'b111110;
  localparam logic [5:0] EL_WR   = 6'b011111;
  localparam logic [5:0] EL_REXP = 6'b010100;
  localparam logic [5:0] EL_WBIT = 6'b001010;
  function automatic int naddr(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction
endpackage

// File: rtl/regfile_bist_addr_gen.sv
// regfile_bist_addr_gen: up/down test-address counter with load-to-start, last flag and MSB held at 0
module regfile_bist_addr_gen
  import regfile_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  down_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);
  localparam logic [ADDR_WIDTH-2:0] TOP = (ADDR_WIDTH-1)'(naddr(ADDR_WIDTH) - 1);
  logic [ADDR_WIDTH-2:0] cnt_q;
  logic                  down_q;
  // Load picks the start end for the new element's direction; the all-ones low address is never reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      down_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      down_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= down_i ? TOP : '0;
      down_q <= down_i;
    end else if (step_i)
      cnt_q <= down_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
  assign addr_o = {1'b0, cnt_q};
  assign last_o = cnt_q == (down_q ? '0 : TOP);
endmodule

// File: rtl/regfile_bist_ctrl.sv
// regfile_bist_ctrl: March C- MBIST initiator for the RF 1RW test port (optional REGFILE_BIST_CHECKERBOARD_EN adds a 0x55/0xAA pass)
module regfile_bist_ctrl
  import regfile_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  setback_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_exp_o,
  output logic [DATA_WIDTH-1:0] fail_act_o,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i
);
`ifdef REGFILE_BIST_CHECKERBOARD_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] PAT_A = {(DATA_WIDTH/2){2'b10}};
  bist_state_e           state_q, state_d;
  march_elem_e           elem_q, elem_d;
  logic                  pass_q, pass_d;
  logic                  load, step, last, mis, go;
  logic                  busy_q, bist_q, done_q, fail_q, csn_q, wen_q;
  logic [DATA_WIDTH-1:0] d_q, fail_exp_q, fail_act_q, exp_rd, bg0_d, bg1_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  assign go     = (state_q == IDLE || state_q == DONE) && start_i;
  assign exp_rd = EL_REXP[elem_q] ? (pass_q ? PAT_A : '1) : (pass_q ? ~PAT_A : '0);
  assign bg0_d  = pass_d ? ~PAT_A : '0;
  assign bg1_d  = pass_d ? PAT_A : '1;
  // Next-state walk through the march elements; a CHK mismatch aborts straight to DONE
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    pass_d  = pass_q;
    load    = 1'b0;
    step    = 1'b0;
    mis     = 1'b0;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = W0;
        elem_d  = M0;
        pass_d  = 1'b0;
        load    = 1'b1;
      end
      W0: if (last) begin
        state_d = RD;
        elem_d  = M1;
        load    = 1'b1;
      end else step = 1'b1;
      RD: state_d = CHK;
      CHK: if (q_t_i != exp_rd) begin
        state_d = DONE;
        mis     = 1'b1;
      end else if (EL_WR[elem_q]) state_d = WR;
      else if (!last) begin
        state_d = RD;
        step    = 1'b1;
      end else if (CB_EN && !pass_q) begin
        state_d = W0;
        elem_d  = M0;
        pass_d  = 1'b1;
        load    = 1'b1;
      end else state_d = DONE;
      WR: begin
        state_d = RD;
        if (last) begin
          elem_d = march_elem_e'(elem_q + 3'd1);
          load   = 1'b1;
        end else step = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  regfile_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (setback_i),
    .load_i (load),
    .down_i (EL_DOWN[elem_d]),
    .step_i (step),
    .addr_o (a_t_o),
    .last_o (last)
  );
  // State plus registered bus/status outputs, decoded from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= M0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      bist_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      d_q         <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (setback_i) begin
      state_q     <= IDLE;
      elem_q      <= M0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      bist_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      d_q         <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      pass_q  <= pass_d;
      busy_q  <= state_d inside {W0, RD, CHK, WR};
      bist_q  <= state_d inside {W0, RD, CHK, WR};
      done_q  <= state_d == DONE;
      csn_q   <= !(state_d inside {W0, RD, WR});
      wen_q   <= !(state_d inside {W0, WR});
      if (state_d inside {W0, WR})
        d_q <= (state_d == WR && EL_WBIT[elem_d]) ? bg1_d : bg0_d;
      if (go) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_act_q  <= '0;
      end else if (mis) begin
        fail_q      <= 1'b1;
        fail_addr_q <= a_t_o;
        fail_exp_q  <= exp_rd;
        fail_act_q  <= q_t_i;
      end
    end
  assign busy_o      = busy_q;
  assign bist_o      = bist_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign csn_t_o     = csn_q;
  assign wen_t_o     = wen_q;
  assign d_t_o       = d_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;
endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// tb_regfile_bist_ctrl: directed vectors against a behavioural RF test-port model with stuck-at faults
module tb_regfile_bist_ctrl;
`ifdef REGFILE_BIST_CHECKERBOARD_EN
  localparam int RUN = 450;
`else
  localparam int RUN = 225;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, setback_i = 1'b0, start_i = 1'b0;
  logic        busy_o, done_o, fail_o, bist_o, csn_t_o, wen_t_o;
  logic [4:0]  fail_addr_o, a_t_o;
  logic [31:0] fail_exp_o, fail_act_o, d_t_o, q_t_i;
  logic [31:0] mem [16];
  logic [4:0]  fa = '0;
  logic [31:0] sa1 = '0, sa0 = '0;
  int          n_run = 0, n_fail = 0, bad = 0;

  typedef struct {
    logic [4:0]  fa;
    logic [31:0] sa1, sa0;
    int          cyc;
    logic        fail;
    logic [4:0]  addr;
    logic [31:0] exp, act;
  } vec_t;
  vec_t v [5];

  regfile_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .setback_i(setback_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_addr_o(fail_addr_o),
    .fail_exp_o(fail_exp_o), .fail_act_o(fail_act_o), .bist_o(bist_o),
    .csn_t_o(csn_t_o), .wen_t_o(wen_t_o), .a_t_o(a_t_o), .d_t_o(d_t_o), .q_t_i(q_t_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bist_o && !csn_t_o) begin
      if (!wen_t_o) mem[a_t_o[3:0]] <= d_t_o;
      else q_t_i <= (mem[a_t_o[3:0]] | (a_t_o == fa ? sa1 : 32'h0)) & ~(a_t_o == fa ? sa0 : 32'h0);
    end

  always @(posedge clk)
    if (rst_n && bist_o && !csn_t_o) begin
      if (a_t_o[4] || a_t_o == 5'h0f) bad++;
`ifdef REGFILE_BIST_CHECKERBOARD_EN
      if (!wen_t_o && !(d_t_o inside {32'h0, 32'hffffffff, 32'h55555555, 32'haaaaaaaa})) bad++;
`else
      if (!wen_t_o && !(d_t_o inside {32'h0, 32'hffffffff})) bad++;
`endif
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int p1, input int p2, input bit ff, output int cyc);
    int t0 = -1;
    int quiet = 0;
    cyc = -1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (t0 < 0 && !csn_t_o) t0 = c;
      if (c == 0) begin
        chk("busy_at_start", {busy_o, bist_o, done_o, fail_o}, 4'b1100);
      end
      if (ff && c == 105) chk("m3_first_rd", {csn_t_o, wen_t_o, a_t_o}, {2'b01, 5'd14});
      if (ff && c == 195) chk("m5_first_rd", {csn_t_o, wen_t_o, a_t_o}, {2'b01, 5'd14});
      if (done_o) begin
        cyc = c - t0;
        break;
      end
      start_i = (c == p1 || c == p2);
      tick();
      start_i = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!csn_t_o || bist_o || busy_o || !done_o) quiet++;
    end
    chk("quiet_after_done", quiet, 0);
  endtask

  initial begin
    int cyc;
    v[0] = '{5'd0,  32'h0, 32'h0,        RUN, 1'b0, 5'd0,  32'h0,        32'h0};
    v[1] = '{5'd10, 32'h8, 32'h0,        47,  1'b1, 5'd10, 32'h0,        32'h8};
    v[2] = '{5'd0,  32'h0, 32'h80000000, 62,  1'b1, 5'd0,  32'hffffffff, 32'h7fffffff};
    v[3] = '{5'd14, 32'h0, 32'h1,        104, 1'b1, 5'd14, 32'hffffffff, 32'hfffffffe};
    v[4] = '{5'd0,  32'h1, 32'h0,        17,  1'b1, 5'd0,  32'h0,        32'h1};
    tick();
    chk("reset_outputs", {busy_o, done_o, fail_o, bist_o, csn_t_o, wen_t_o, a_t_o, d_t_o}, {6'b000011, 5'd0, 32'h0});
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      fa = v[i].fa; sa1 = v[i].sa1; sa0 = v[i].sa0;
      run(-1, -1, !v[i].fail, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
      chk($sformatf("v%0d_fail", i), fail_o, v[i].fail);
      if (v[i].fail) chk($sformatf("v%0d_info", i), {fail_addr_o, fail_exp_o, fail_act_o}, {v[i].addr, v[i].exp, v[i].act});
    end
    // new start after a failing run clears done/fail
    fa = '0; sa1 = '0; sa0 = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart_clears", {done_o, fail_o, busy_o}, 3'b001);
    // setback mid-run releases the bus on the next cycle
    for (int i = 0; i < 39; i++) tick();
    setback_i = 1'b1;
    tick();
    setback_i = 1'b0;
    chk("setback_release", {busy_o, bist_o, csn_t_o, done_o, a_t_o}, {4'b0010, 5'd0});
    run(-1, -1, 1'b1, cyc);
    chk("after_setback_cycles", cyc, RUN);
    chk("after_setback_fail", fail_o, 1'b0);
    // start pulses while busy are ignored
    run(10, 100, 1'b1, cyc);
    chk("ignored_start_cycles", cyc, RUN);
    // async reset mid-run
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy_o, bist_o, csn_t_o, wen_t_o}, 4'b0011);
    #2 rst_n = 1'b1;
    tick();
    run(-1, -1, 1'b1, cyc);
    chk("after_reset_cycles", cyc, RUN);
    chk("bus_addr_data_legal", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
